// File: rtl/bp_fe_pkg.sv
`default_nettype none
// bp_fe_pkg: front-end shared types, default BTB geometry and PC field helpers (rev 1.0)
package bp_fe_pkg;

  localparam int unsigned btb_eaddr_width_gp  = 39;
  localparam int unsigned btb_sets_gp         = 64;
  localparam int unsigned btb_ways_gp         = 2;
  localparam int unsigned btb_tag_width_gp    = 10;
  localparam int unsigned btb_offset_width_gp = 2;
  localparam int unsigned btb_tag_max_gp      = 32;

  // Tags are held zero-extended so one entry type serves every tag width.
  typedef struct packed {
    logic                      v;
    logic [btb_tag_max_gp-1:0] tag;
  } bp_fe_btb_entry_s;

  function automatic logic [63:0] bp_fe_btb_field(input logic [63:0] pc,
                                                  input int unsigned lsb,
                                                  input int unsigned width);
    logic [63:0] mask;
    mask = ~(64'hFFFF_FFFF_FFFF_FFFF << width);
    return (pc >> lsb) & mask;
  endfunction

  function automatic logic [63:0] bp_fe_btb_idx(input logic [63:0] pc,
                                                input int unsigned offset_w,
                                                input int unsigned idx_w);
    return bp_fe_btb_field(pc, offset_w, idx_w);
  endfunction

  function automatic logic [63:0] bp_fe_btb_tag(input logic [63:0] pc,
                                                input int unsigned offset_w,
                                                input int unsigned idx_w,
                                                input int unsigned tag_w);
    return bp_fe_btb_field(pc, offset_w + idx_w, tag_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_fe_btb_repl.sv
`default_nettype none
// bp_fe_btb_repl: per-set replacement state; tree PLRU with BP_FE_BTB_PLRU_EN, else round-robin (rev 1.0)
module bp_fe_btb_repl
  import bp_fe_pkg::*;
#(
  parameter int unsigned sets_p = btb_sets_gp,
  parameter int unsigned ways_p = btb_ways_gp,
  localparam int unsigned idx_w = $clog2(sets_p),
  localparam int unsigned way_w = (ways_p > 1) ? $clog2(ways_p) : 1
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             flush_i,
  input  logic             rd_touch_v_i,
  input  logic [idx_w-1:0] rd_touch_set_i,
  input  logic [way_w-1:0] rd_touch_way_i,
  input  logic             wr_touch_v_i,
  input  logic [idx_w-1:0] wr_set_i,
  input  logic [way_w-1:0] wr_way_i,
  input  logic             alloc_full_v_i,
  output logic [way_w-1:0] victim_o
);

  logic unused_ok;
  assign unused_ok = ^{clk_i, reset_n_i, flush_i, rd_touch_v_i, rd_touch_set_i,
                       rd_touch_way_i, wr_touch_v_i, wr_set_i, wr_way_i, alloc_full_v_i};

  if (ways_p == 1) begin : g_direct
    assign victim_o = '0;
  end else begin : g_state
`ifdef BP_FE_BTB_PLRU_EN
    localparam int unsigned st_w = ways_p - 1;
`else
    localparam int unsigned st_w = way_w;
`endif
    logic [st_w-1:0] state_q [sets_p];
    logic [st_w-1:0] state_d [sets_p];

`ifdef BP_FE_BTB_PLRU_EN
    // Bit 0 is the root; bits 1/2 pick within the low/high pair. 0 = go low.
    function automatic logic [st_w-1:0] plru_touch(input logic [st_w-1:0] s,
                                                   input logic [way_w-1:0] w);
      logic [2:0] t;
      logic [1:0] w2;
      t  = 3'(s);
      w2 = 2'(w);
      if (ways_p == 2) t[0] = ~w2[0];
      else begin
        t[0] = ~w2[1];
        if (w2[1]) t[2] = ~w2[0];
        else       t[1] = ~w2[0];
      end
      return st_w'(t);
    endfunction

    always_comb begin
      logic [2:0] t;
      logic [1:0] v;
      t = 3'(state_q[wr_set_i]);
      if (ways_p == 2) v = {1'b0, t[0]};
      else             v = {t[0], t[0] ? t[2] : t[1]};
      victim_o = way_w'(v);
    end

    always_comb begin
      state_d = state_q;
      if (rd_touch_v_i) state_d[rd_touch_set_i] = plru_touch(state_d[rd_touch_set_i], rd_touch_way_i);
      if (wr_touch_v_i) state_d[wr_set_i] = plru_touch(state_d[wr_set_i], wr_way_i);
      if (flush_i) for (int s = 0; s < sets_p; s++) state_d[s] = '0;
    end
`else
    assign victim_o = state_q[wr_set_i];

    always_comb begin
      state_d = state_q;
      if (alloc_full_v_i) state_d[wr_set_i] = state_q[wr_set_i] + st_w'(1);
      if (flush_i) for (int s = 0; s < sets_p; s++) state_d[s] = '0;
    end
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        for (int s = 0; s < sets_p; s++) state_q[s] <= '0;
      end else begin
        state_q <= state_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bsg_mem_1r1w_sync.sv
`default_nettype none
// bsg_mem_1r1w_sync: one-write one-read memory with registered read data (rev 1.0)
module bsg_mem_1r1w_sync #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 2,
  localparam int unsigned addr_w = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               w_v_i,
  input  logic [addr_w-1:0]  w_addr_i,
  input  logic [width_p-1:0] w_data_i,
  input  logic               r_v_i,
  input  logic [addr_w-1:0]  r_addr_i,
  output logic [width_p-1:0] r_data_o
);

  logic [width_p-1:0] mem [els_p];
  logic [width_p-1:0] r_data_q;
  logic               unused_ok;

  always_ff @(posedge clk_i) begin
    if (w_v_i) mem[w_addr_i] <= w_data_i;
    if (r_v_i) r_data_q <= mem[r_addr_i];
  end

  assign r_data_o  = r_data_q;
  assign unused_ok = reset_i;

endmodule
`default_nettype wire

// File: rtl/bp_fe_btb_assoc.sv
`default_nettype none
// bp_fe_btb_assoc: tagged set-associative BTB, 1-cycle lookup with write forwarding.
// Victim policy selected by BP_FE_BTB_PLRU_EN (tree PLRU) or round-robin when undefined. (rev 1.0)
module bp_fe_btb_assoc
  import bp_fe_pkg::*;
#(
  parameter int unsigned eaddr_width_p      = btb_eaddr_width_gp,
  parameter int unsigned btb_sets_p         = btb_sets_gp,
  parameter int unsigned btb_ways_p         = btb_ways_gp,
  parameter int unsigned btb_tag_width_p    = btb_tag_width_gp,
  parameter int unsigned btb_offset_width_p = btb_offset_width_gp
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     r_v_i,
  input  logic [eaddr_width_p-1:0] r_pc_i,
  output logic                     r_v_o,
  output logic                     r_hit_o,
  output logic [eaddr_width_p-1:0] r_br_tgt_o,
  input  logic                     w_v_i,
  input  logic                     w_clr_i,
  input  logic [eaddr_width_p-1:0] w_pc_i,
  input  logic [eaddr_width_p-1:0] w_br_tgt_i,
  input  logic                     flush_i
);

  localparam int unsigned idx_w = $clog2(btb_sets_p);
  localparam int unsigned way_w = (btb_ways_p > 1) ? $clog2(btb_ways_p) : 1;

  bp_fe_btb_entry_s entry_q [btb_sets_p][btb_ways_p];
  bp_fe_btb_entry_s entry_d [btb_sets_p][btb_ways_p];

  logic [idx_w-1:0]          r_idx, w_idx, r_idx_q, r_idx_d;
  logic [btb_tag_max_gp-1:0] r_tag, w_tag;
  logic [btb_ways_p-1:0]     w_hit_vec, hit_vec_d, hit_vec_q;
  logic [way_w-1:0]          w_hit_way, w_inv_way, w_way, victim, r_hit_way, rd_way;
  logic                      w_hit, w_any_inv, w_we, w_ce, alloc_full;
  logic                      r_v_d, r_v_q, hit_d, hit_q, fwd_d, fwd_q;
  logic [eaddr_width_p-1:0]  fwd_tgt_d, fwd_tgt_q, tgt;
  logic [eaddr_width_p-1:0]  sram_data [btb_ways_p];

  assign r_idx = idx_w'(bp_fe_btb_idx(64'(r_pc_i), btb_offset_width_p, idx_w));
  assign w_idx = idx_w'(bp_fe_btb_idx(64'(w_pc_i), btb_offset_width_p, idx_w));
  assign r_tag = btb_tag_max_gp'(bp_fe_btb_tag(64'(r_pc_i), btb_offset_width_p, idx_w, btb_tag_width_p));
  assign w_tag = btb_tag_max_gp'(bp_fe_btb_tag(64'(w_pc_i), btb_offset_width_p, idx_w, btb_tag_width_p));

  // Update: hit way, else lowest invalid way, else the replacement victim.
  always_comb begin
    w_hit_vec = '0;
    w_hit_way = '0;
    w_inv_way = '0;
    w_any_inv = 1'b0;
    for (int k = 0; k < btb_ways_p; k++) begin
      w_hit_vec[k] = entry_q[w_idx][k].v && (entry_q[w_idx][k].tag == w_tag);
      if (w_hit_vec[k]) w_hit_way = way_w'(k);
      if (!entry_q[w_idx][k].v && !w_any_inv) begin
        w_any_inv = 1'b1;
        w_inv_way = way_w'(k);
      end
    end
    w_hit      = |w_hit_vec;
    w_way      = w_hit ? w_hit_way : (w_any_inv ? w_inv_way : victim);
    w_we       = w_v_i & ~flush_i & ~w_clr_i;
    w_ce       = w_v_i & ~flush_i & w_clr_i & w_hit;
    alloc_full = w_we & ~w_hit & ~w_any_inv;
  end

  always_comb begin
    entry_d = entry_q;
    if (w_we) entry_d[w_idx][w_way] = '{v: 1'b1, tag: w_tag};
    if (w_ce) entry_d[w_idx][w_way].v = 1'b0;
    if (flush_i) begin
      for (int s = 0; s < btb_sets_p; s++)
        for (int k = 0; k < btb_ways_p; k++) entry_d[s][k].v = 1'b0;
    end
  end

  // Lookup sees the post-update table, so same-cycle writes, clears and flush all apply.
  always_comb begin
    hit_vec_d = '0;
    r_hit_way = '0;
    for (int k = 0; k < btb_ways_p; k++) begin
      hit_vec_d[k] = r_v_i && entry_d[r_idx][k].v && (entry_d[r_idx][k].tag == r_tag);
      if (hit_vec_d[k]) r_hit_way = way_w'(k);
    end
    hit_d     = |hit_vec_d;
    fwd_d     = w_we && (w_idx == r_idx) && hit_d && (r_hit_way == w_way);
    fwd_tgt_d = w_br_tgt_i;
    r_v_d     = r_v_i;
    r_idx_d   = r_idx;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_v_q     <= 1'b0;
      hit_q     <= 1'b0;
      hit_vec_q <= '0;
      fwd_q     <= 1'b0;
      fwd_tgt_q <= '0;
      r_idx_q   <= '0;
      for (int s = 0; s < btb_sets_p; s++)
        for (int k = 0; k < btb_ways_p; k++) entry_q[s][k] <= '0;
    end else begin
      r_v_q     <= r_v_d;
      hit_q     <= hit_d;
      hit_vec_q <= hit_vec_d;
      fwd_q     <= fwd_d;
      fwd_tgt_q <= fwd_tgt_d;
      r_idx_q   <= r_idx_d;
      entry_q   <= entry_d;
    end
  end

  for (genvar k = 0; k < btb_ways_p; k++) begin : g_way
    bsg_mem_1r1w_sync #(
      .width_p(eaddr_width_p),
      .els_p  (btb_sets_p)
    ) u_tgt_mem (
      .clk_i   (clk_i),
      .reset_i (~reset_n_i),
      .w_v_i   (w_we && (w_way == way_w'(k))),
      .w_addr_i(w_idx),
      .w_data_i(w_br_tgt_i),
      .r_v_i   (r_v_i),
      .r_addr_i(r_idx),
      .r_data_o(sram_data[k])
    );
  end

  always_comb begin
    tgt    = '0;
    rd_way = '0;
    for (int k = 0; k < btb_ways_p; k++) begin
      if (hit_vec_q[k]) begin
        tgt    = tgt | sram_data[k];
        rd_way = way_w'(k);
      end
    end
    if (fwd_q) tgt = fwd_tgt_q;
  end

  bp_fe_btb_repl #(
    .sets_p(btb_sets_p),
    .ways_p(btb_ways_p)
  ) u_repl (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .flush_i       (flush_i),
    .rd_touch_v_i  (hit_q),
    .rd_touch_set_i(r_idx_q),
    .rd_touch_way_i(rd_way),
    .wr_touch_v_i  (w_we),
    .wr_set_i      (w_idx),
    .wr_way_i      (w_way),
    .alloc_full_v_i(alloc_full),
    .victim_o      (victim)
  );

  assign r_v_o      = r_v_q;
  assign r_hit_o    = hit_q;
  assign r_br_tgt_o = tgt;

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_btb_assoc.sv
`default_nettype none
// tb_bp_fe_btb_assoc: directed checks of lookup, update, replacement, forwarding, clear, flush and reset.
module tb_bp_fe_btb_assoc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        r_v_i, w_v_i, w_clr_i, flush_i;
  logic [38:0] r_pc_i, w_pc_i, w_br_tgt_i;
  logic        r_v_o, r_hit_o;
  logic [38:0] r_br_tgt_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  bp_fe_btb_assoc #(
    .eaddr_width_p(39), .btb_sets_p(64), .btb_ways_p(2),
    .btb_tag_width_p(10), .btb_offset_width_p(2)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .r_v_i(r_v_i), .r_pc_i(r_pc_i),
    .r_v_o(r_v_o), .r_hit_o(r_hit_o), .r_br_tgt_o(r_br_tgt_o),
    .w_v_i(w_v_i), .w_clr_i(w_clr_i), .w_pc_i(w_pc_i), .w_br_tgt_i(w_br_tgt_i),
    .flush_i(flush_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [38:0] rpc, input logic wv, input logic wclr,
                       input logic [38:0] wpc, input logic [38:0] wtgt, input logic fl);
    r_v_i = rv; r_pc_i = rpc; w_v_i = wv; w_clr_i = wclr;
    w_pc_i = wpc; w_br_tgt_i = wtgt; flush_i = fl;
    @(posedge clk); #1;
    r_v_i = 1'b0; w_v_i = 1'b0; w_clr_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic rd(input logic [38:0] pc);
    drive(1'b1, pc, 1'b0, 1'b0, 39'h0, 39'h0, 1'b0);
  endtask

  task automatic wr(input logic [38:0] pc, input logic [38:0] t);
    drive(1'b0, 39'h0, 1'b1, 1'b0, pc, t, 1'b0);
  endtask

  task automatic clr(input logic [38:0] pc);
    drive(1'b0, 39'h0, 1'b1, 1'b1, pc, 39'h0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 39'h0, 1'b0, 1'b0, 39'h0, 39'h0, 1'b0);
  endtask

  task automatic expect_rd(input string tag, input logic hit, input logic [38:0] t);
    check({tag, "_v"},   64'(r_v_o),      64'(1'b1));
    check({tag, "_hit"}, 64'(r_hit_o),    64'(hit));
    check({tag, "_tgt"}, 64'(r_br_tgt_o), 64'(t));
  endtask

  initial begin
    reset_n = 1'b0;
    r_v_i = 1'b0; w_v_i = 1'b0; w_clr_i = 1'b0; flush_i = 1'b0;
    r_pc_i = '0; w_pc_i = '0; w_br_tgt_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_v",   64'(r_v_o),      64'(0));
    check("rst_hit", 64'(r_hit_o),    64'(0));
    check("rst_tgt", 64'(r_br_tgt_o), 64'(0));
    reset_n = 1'b1;

    rd(39'h1000);              expect_rd("cold", 1'b0, 39'h0);
    idle();
    check("idle_v",   64'(r_v_o),   64'(0));
    check("idle_hit", 64'(r_hit_o), 64'(0));

    wr(39'h1000, 39'h2000);
    rd(39'h1000);              expect_rd("wr_hit", 1'b1, 39'h2000);
    rd(39'h1100);              expect_rd("tag_flip", 1'b0, 39'h0);
    rd(39'h4000_1000);         expect_rd("high_bits", 1'b1, 39'h2000);

    // Set 5: A=0x114, B=0x214, C=0x314, D=0x414
    wr(39'h114, 39'hA0);
    wr(39'h214, 39'hB0);
    rd(39'h114);               expect_rd("s5_a", 1'b1, 39'hA0);
    idle();
    wr(39'h314, 39'hC0);
`ifdef BP_FE_BTB_PLRU_EN
    rd(39'h314);               expect_rd("s5_c1", 1'b1, 39'hC0);
    rd(39'h214);               expect_rd("s5_b1", 1'b0, 39'h0);
    rd(39'h114);               expect_rd("s5_a1", 1'b1, 39'hA0);
    idle();
    wr(39'h414, 39'hD0);
    rd(39'h114);               expect_rd("s5_a2", 1'b1, 39'hA0);
    rd(39'h214);               expect_rd("s5_b2", 1'b0, 39'h0);
    rd(39'h314);               expect_rd("s5_c2", 1'b0, 39'h0);
    rd(39'h414);               expect_rd("s5_d2", 1'b1, 39'hD0);
`else
    rd(39'h314);               expect_rd("s5_c1", 1'b1, 39'hC0);
    rd(39'h214);               expect_rd("s5_b1", 1'b1, 39'hB0);
    rd(39'h114);               expect_rd("s5_a1", 1'b0, 39'h0);
    idle();
    wr(39'h414, 39'hD0);
    rd(39'h114);               expect_rd("s5_a2", 1'b0, 39'h0);
    rd(39'h214);               expect_rd("s5_b2", 1'b0, 39'h0);
    rd(39'h314);               expect_rd("s5_c2", 1'b1, 39'hC0);
    rd(39'h414);               expect_rd("s5_d2", 1'b1, 39'hD0);
`endif

    drive(1'b1, 39'h1000, 1'b1, 1'b0, 39'h1000, 39'h3000, 1'b0);
    expect_rd("fwd_hitway", 1'b1, 39'h3000);
    rd(39'h1000);              expect_rd("after_fwd", 1'b1, 39'h3000);
    drive(1'b1, 39'h5000, 1'b1, 1'b0, 39'h5000, 39'h5555, 1'b0);
    expect_rd("fwd_alloc", 1'b1, 39'h5555);

    clr(39'h1000);
    rd(39'h1000);              expect_rd("clr_miss", 1'b0, 39'h0);
    clr(39'h7000);
    rd(39'h5000);              expect_rd("clr_absent", 1'b1, 39'h5555);
    drive(1'b1, 39'h5000, 1'b1, 1'b1, 39'h5000, 39'h0, 1'b0);
    expect_rd("clr_same", 1'b0, 39'h0);

    for (int s = 0; s < 8; s++) wr(39'h2000 | 39'((8 + s) << 2), 39'(32'h8000 + s));
    for (int s = 0; s < 8; s++) begin
      rd(39'h2000 | 39'((8 + s) << 2));
      expect_rd($sformatf("fill%0d", s), 1'b1, 39'(32'h8000 + s));
    end

    drive(1'b1, 39'h2020, 1'b1, 1'b0, 39'h2040, 39'h9999, 1'b1);
    expect_rd("flush_rd", 1'b0, 39'h0);
    for (int s = 0; s < 8; s++) begin
      rd(39'h2000 | 39'((8 + s) << 2));
      expect_rd($sformatf("post_flush%0d", s), 1'b0, 39'h0);
    end
    rd(39'h2040);              expect_rd("flush_wr_drop", 1'b0, 39'h0);
    rd(39'h414);               expect_rd("flush_s5", 1'b0, 39'h0);
    wr(39'h2020, 39'h1234);
    rd(39'h2020);              expect_rd("post_flush_wr", 1'b1, 39'h1234);

    r_v_i = 1'b1; r_pc_i = 39'h2020;
    @(posedge clk); #1;
    check("stream_v", 64'(r_v_o), 64'(1));
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_v",   64'(r_v_o),      64'(0));
    check("async_rst_hit", 64'(r_hit_o),    64'(0));
    check("async_rst_tgt", 64'(r_br_tgt_o), 64'(0));
    r_v_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
